mem_burst_master: RTL
=====================

# mem_burst_master

Initiator-side controller for the single-port synchronous memory's valid/ready interface. It accepts burst commands (start address, beat count, direction), pulls write data from an input stream, and returns read data on an output stream with backpressure. It sequences one memory access per beat, wrapping addresses modulo DEPTH, and guards each access with a ready timeout. It sits between system-level data movers and the memory instance.

## Interface

- WIDTH, 8, data width; must match the memory.
- DEPTH, 16, memory locations; power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 8, maximum cycles spent in WAIT before the access is declared failed (≥1).

Ports:
- clk_i  in  1  single clock; all logic updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when both cmd_valid_i and cmd_ready_o are high at an edge.
- cmd_write_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  ADDR_WIDTH  start address.
- cmd_len_i  in  ADDR_WIDTH+1  beat count, 0..2^(ADDR_WIDTH+1)-1.
- wdata_valid_i  in  1  write beat offered.
- wdata_ready_o  out  1  write beat taken on handshake.
- wdata_i  in  WIDTH  write beat data.
- rdata_valid_o  out  1  read beat presented.
- rdata_ready_i  in  1  read beat consumed on handshake.
- rdata_o  out  WIDTH  read beat data.
- mem_valid_o  out  1  to memory valid_i.
- mem_write_read_o  out  1  to memory write_read_i.
- mem_addr_o  out  ADDR_WIDTH  to memory addr_i.
- mem_write_data_o  out  WIDTH  to memory write_data_i.
- mem_ready_i  in  1  from memory ready_o.
- mem_read_data_i  in  WIDTH  from memory read_data_o.
- busy_o  out  1  high whenever state ≠ IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky timeout flag.

## Operation

- States: IDLE, FETCH, ISSUE, WAIT, PUSH. All outputs are decoded from registers only; no combinational input-to-output paths.
- IDLE: cmd_ready_o=1. On accept, latch direction, address, and length, and clear err_o. If the length is 0, pulse done_o and stay in IDLE. Otherwise go to FETCH for a write or ISSUE for a read.
- FETCH (write only): wdata_ready_o=1. On wdata handshake, latch wdata_i into mem_write_data_o and go to ISSUE.
- ISSUE: mem_valid_o=1 for exactly one cycle, with mem_addr_o, mem_write_read_o, and mem_write_data_o stable. Next state is WAIT. mem_ready_i is ignored in ISSUE.
- WAIT: mem_valid_o=0. The timeout counter starts at 0 on entry and increments each cycle.
  - On mem_ready_i=1 with a read burst, capture mem_read_data_i into rdata_o and go to PUSH.
  - On mem_ready_i=1 with a write burst, the beat is complete.
  - If the counter reaches TIMEOUT without mem_ready_i, set err_o, pulse done_o, and go to IDLE. The remaining beats are dropped.
- PUSH: rdata_valid_o=1, and rdata_o is held until the handshake. The beat completes on handshake.
- Beat complete: decrement the remaining count and increment the address modulo 2^ADDR_WIDTH (15→0 wraps). If the remaining count is 0, go to IDLE and pulse done_o in the IDLE cycle. Otherwise go to FETCH for a write or ISSUE for a read.
- Lengths greater than DEPTH are legal; the addresses keep wrapping.
- Reset values: cmd_ready_o=0 during reset and 1 from the first post-reset cycle. All other outputs are 0: wdata_ready_o, rdata_valid_o, rdata_o, mem_valid_o, mem_write_read_o, mem_addr_o, mem_write_data_o, busy_o, done_o, err_o. State returns to IDLE and the counters clear.
- Reset mid-burst: the burst is discarded at that edge, with no done_o and no err_o.

## Timing

- Beat latency is 3 cycles when the streams never stall:
  - Write: FETCH, ISSUE, WAIT.
  - Read: ISSUE, WAIT, PUSH.
- The memory raises ready one cycle after it samples valid, so WAIT normally lasts exactly 1 cycle.
- done_o is high in the first IDLE cycle after the last beat. A new command may be accepted in that same cycle.
- Total cycles from accept to done_o for an N-beat burst with no stalls: 3N+1.
- A stall on wdata_valid_i or rdata_ready_i extends FETCH or PUSH indefinitely. No timeout applies to the streams.
- cmd_len_i=0: done_o is high in the cycle after accept, and no mem_valid_o is generated.

## Test plan

- Write burst, addr=14, len=4, data 0xA1..0xA4, streams never stalled:
  - mem_valid_o pulses at addresses 14, 15, 0, 1.
  - done_o is high 13 cycles after accept.
  - The memory then holds mem[14]=0xA1, mem[15]=0xA2, mem[0]=0xA3, mem[1]=0xA4.
- Read burst, addr=14, len=4, following the previous write: the rdata_o sequence is 0xA1, 0xA2, 0xA3, 0xA4, with rdata_valid_o high for 1 cycle each while rdata_ready_i=1.
- Read with rdata_ready_i low for 5 cycles on beat 2: rdata_o stays stable while rdata_valid_o=1, and no new mem_valid_o is issued until the handshake.
- Memory held in reset (mem_ready_i=0), read of len=2, TIMEOUT=8: err_o is set after 8 WAIT cycles, done_o pulses once, and only one mem_valid_o pulse is seen.
- len=0 write: done_o pulses the cycle after accept; wdata_ready_o and mem_valid_o never assert.
- rst_i asserted during WAIT of beat 3 of 5: on the next cycle all outputs are at their reset values, and done_o and err_o are 0. A new command is accepted normally afterwards.

Source files
------------

// File: rtl/mem_burst_master.sv
// mem_burst_master: burst command sequencer for a valid/ready single-port memory, with stream-side data and per-access timeout.
module mem_burst_master #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  mem_valid_o,
  output logic                  mem_write_read_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_write_data_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_read_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] PUSH  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  rdy_q, rdy_d;
  logic                  beat;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    rdy_d   = 1'b1;
    beat    = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i && rdy_q) begin
        write_d = cmd_write_i;
        addr_d  = cmd_addr_i;
        len_d   = cmd_len_i;
        err_d   = 1'b0;
        done_d  = cmd_len_i == '0;
        state_d = cmd_len_i == '0 ? IDLE : cmd_write_i ? FETCH : ISSUE;
      end
      FETCH: if (wdata_valid_i) begin
        wdata_d = wdata_i;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (mem_ready_i) begin
        beat    = write_q;
        rdata_d = write_q ? rdata_q : mem_read_data_i;
        state_d = write_q ? WAIT : PUSH;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      PUSH: beat = rdata_ready_i;
      default: state_d = IDLE;
    endcase
    // a completed beat overrides the per-state next state chosen above
    if (beat) begin
      len_d   = len_q - (ADDR_WIDTH + 1)'(1);
      addr_d  = addr_q + ADDR_WIDTH'(1);
      done_d  = len_q == (ADDR_WIDTH + 1)'(1);
      state_d = len_q == (ADDR_WIDTH + 1)'(1) ? IDLE : write_q ? FETCH : ISSUE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign cmd_ready_o      = rdy_q && state_q == IDLE;
  assign wdata_ready_o    = state_q == FETCH;
  assign rdata_valid_o    = state_q == PUSH;
  assign rdata_o          = rdata_q;
  assign mem_valid_o      = state_q == ISSUE;
  assign mem_write_read_o = write_q;
  assign mem_addr_o       = addr_q;
  assign mem_write_data_o = wdata_q;
  assign busy_o           = state_q != IDLE;
  assign done_o           = done_q;
  assign err_o            = err_q;
endmodule
